rv_ctrl_fsm: RTL and testbench
==============================

Name: rv_ctrl_fsm

Overview:
- Multicycle control unit that sits at the driving end of the ALU opcode interface.
- Decodes the latched RV32I instruction word and sequences FETCH/DECODE/EXEC/MEM/WB.
- Produces aluOp and the datapath mux selects and write strobes, and counts retired instructions.
- The ALU, PC, IR, register file and branch comparator stay in the datapath. This block contains only control and the retire counter.

Parameters:
CNT_W, 32, width of the instret counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
ir  in  32  instruction register contents, valid from DECODE onward
mem_ready  in  1  memory handshake; the access completes in the cycle it is high
br_taken  in  1  branch comparator result for ir funct3
aluOp  out  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9
alu_srcA_sel  out  2  0=rs1 1=PC 2=zero
alu_srcB_sel  out  3  0=rs2 1=I-imm 2=S-imm 3=U-imm 4=const 4
pc_sel  out  2  0=PC+4 1=branch target 2=JAL target 3=JALR target
pc_we  out  1  PC write strobe
ir_we  out  1  IR load strobe
rf_we  out  1  register file write strobe
rf_wsel  out  1  0=ALU result 1=memory data
mem_re  out  1  memory read request (instruction fetch or load)
mem_we  out  1  memory write request
illegal  out  1  sticky illegal-instruction flag
instret  out  CNT_W  retired instruction count

Behaviour:
- Reset and idle values:
  - While rst is high: state=FETCH, instret=0, illegal=0.
  - All strobes (pc_we, ir_we, rf_we, mem_re, mem_we) are forced 0 combinationally, including the cycle rst deasserts asynchronously.
  - aluOp=0, all selects=0.
- Outputs are Moore-style from the state register plus ir decode. Strobes must never assert outside the states listed below.
- FETCH:
  - mem_re=1.
  - When mem_ready=1: ir_we=1 in the same cycle, next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - No strobes.
  - Illegal instruction -> TRAP. Otherwise -> EXEC.
- EXEC, by opcode:
  - OP (0110011): srcA=0, srcB=0; rf_we=1, pc_we=1, pc_sel=0 -> FETCH.
  - OP-IMM (0010011): srcA=0, srcB=1; rf_we=1, pc_we=1, pc_sel=0 -> FETCH.
  - LUI: srcA=2, srcB=3, ADD; rf_we, pc_we -> FETCH.
  - AUIPC: srcA=1, srcB=3, ADD; rf_we, pc_we -> FETCH.
  - JAL/JALR: srcA=1, srcB=4, ADD; rf_we=1, pc_we=1, pc_sel=2 or 3 -> FETCH.
  - BRANCH: aluOp=ADD; pc_we=1; pc_sel = br_taken ? 1 : 0 -> FETCH.
  - LOAD: srcA=0, srcB=1, ADD -> MEM.
  - STORE: srcA=0, srcB=2, ADD -> MEM.
- aluOp decode by funct3:
  - 000: ADD; SUB only for OP with ir[30]=1.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: ir[30] ? SRA : SRL (both OP and OP-IMM).
  - 110: OR. 111: AND.
- MEM:
  - Load: mem_re=1. Store: mem_we=1. The strobe is held until mem_ready=1.
  - Load with mem_ready -> WB.
  - Store with mem_ready -> pc_we=1, pc_sel=0 in that cycle, then FETCH.
- WB: rf_we=1, rf_wsel=1, pc_we=1, pc_sel=0 -> FETCH.
- instret increments by 1 on each cycle in which pc_we=1. It wraps at 2^CNT_W-1 -> 0 without saturation.
- TRAP: illegal=1, no strobes, aluOp=0. Exited only by rst.
- Illegal conditions:
  - ir[1:0]!=11, or opcode not in {OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE}. FENCE and SYSTEM are illegal.
  - OP with funct7 not in {0000000, 0100000}, or funct7=0100000 with funct3 not in {000, 101}.
  - OP-IMM with funct3=001 and ir[31:25]!=0, or funct3=101 and ir[31:25] not in {0000000, 0100000}.
  - BRANCH funct3 in {010, 011}. LOAD funct3 in {011, 110, 111}. STORE funct3>010. JALR funct3!=000.
- Latency with mem_ready constantly high: ALU/jump/branch 3 cycles, store 4, load 5.
- Reset mid-operation: an in-flight strobe drops immediately, and an access that has not completed does not count toward instret.

Test Plan:
1. add 0x002081B3, mem_ready=1 -> FETCH(ir_we), DECODE, EXEC with aluOp=0, srcA=0, srcB=0, rf_we=1, pc_we=1, pc_sel=0; instret 0->1.
2. sub 0x402081B3 -> aluOp=1. sra 0x4020D1B3 -> aluOp=7, srcB=0. srai 0x4040D193 -> aluOp=7, srcB=1. Each run retires exactly 1 instruction.
3. lw 0x0080A283, mem_ready low for the first 3 MEM cycles -> EXEC srcB=1, aluOp=0; mem_re held 4 MEM cycles; WB rf_we=1, rf_wsel=1; 8 cycles total.
4. beq 0x00208463 with br_taken=1 -> EXEC pc_sel=1, pc_we=1, rf_we=0. Repeated with br_taken=0 -> pc_sel=0.
5. 0xFFFFFFFF -> DECODE then TRAP; illegal=1 held for 10+ cycles; no strobes; instret unchanged. rst pulse -> FETCH, illegal=0.
6. sw 0x0020A423 with mem_ready=0, rst asserted mid-MEM -> mem_we falls with no clock edge; instret stays at its pre-reset value until rst clears it to 0; mem_re=1 in FETCH after rst releases.

Source files
------------

// File: rtl/rv_ctrl_if.sv
// Control/datapath boundary of the multicycle RV32I core: instruction word and
// handshakes in, ALU opcode, mux selects and write strobes out.
interface rv_ctrl_if;
  logic [31:0] ir;
  logic        mem_ready;
  logic        br_taken;
  logic [3:0]  aluOp;
  logic [1:0]  alu_srcA_sel;
  logic [2:0]  alu_srcB_sel;
  logic [1:0]  pc_sel;
  logic        pc_we;
  logic        ir_we;
  logic        rf_we;
  logic        rf_wsel;
  logic        mem_re;
  logic        mem_we;

  modport master (
    input  ir, mem_ready, br_taken,
    output aluOp, alu_srcA_sel, alu_srcB_sel, pc_sel,
           pc_we, ir_we, rf_we, rf_wsel, mem_re, mem_we
  );

  modport slave (
    output ir, mem_ready, br_taken,
    input  aluOp, alu_srcA_sel, alu_srcB_sel, pc_sel,
           pc_we, ir_we, rf_we, rf_wsel, mem_re, mem_we
  );
endinterface

// File: rtl/rv_ctrl_fsm.sv
// Multicycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with a
// retired-instruction counter; all datapath storage lives outside.
module rv_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  rv_ctrl_if.master        bus,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;

  logic [2:0] state, state_nx;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       bad, unused;
  logic [3:0] alu_f;
  logic       pc_we_c, ir_we_c, rf_we_c, mem_re_c, mem_we_c;

  assign opc    = bus.ir[6:0];
  assign f3     = bus.ir[14:12];
  assign f7     = bus.ir[31:25];
  assign unused = ^{bus.ir[24:15], bus.ir[11:7]};

  // Every legal opcode ends in 2'b11, so the opcode match also screens ir[1:0].
  always_comb begin
    bad = 1'b0;
    case (opc)
      OPC_OP:     bad = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      OPC_OPIMM:  bad = (f3 == 3'd1 && f7 != 7'h00) ||
                        (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      OPC_LUI, OPC_AUIPC, OPC_JAL: bad = 1'b0;
      OPC_JALR:   bad = (f3 != 3'd0);
      OPC_BRANCH: bad = (f3 == 3'd2 || f3 == 3'd3);
      OPC_LOAD:   bad = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      OPC_STORE:  bad = (f3 > 3'd2);
      default:    bad = 1'b1;
    endcase
  end

  // SUB only exists in register-register form; OP-IMM funct3=000 is always ADDI.
  always_comb begin
    alu_f = ALU_ADD;
    case (f3)
      3'd0: alu_f = (opc == OPC_OP && bus.ir[30]) ? ALU_SUB : ALU_ADD;
      3'd1: alu_f = ALU_SLL;
      3'd2: alu_f = ALU_SLT;
      3'd3: alu_f = ALU_SLTU;
      3'd4: alu_f = ALU_XOR;
      3'd5: alu_f = bus.ir[30] ? ALU_SRA : ALU_SRL;
      3'd6: alu_f = ALU_OR;
      default: alu_f = ALU_AND;
    endcase
  end

  always_comb begin
    state_nx         = state;
    bus.aluOp        = ALU_ADD;
    bus.alu_srcA_sel = 2'd0;
    bus.alu_srcB_sel = 3'd0;
    bus.pc_sel       = 2'd0;
    bus.rf_wsel      = 1'b0;
    pc_we_c  = 1'b0;
    ir_we_c  = 1'b0;
    rf_we_c  = 1'b0;
    mem_re_c = 1'b0;
    mem_we_c = 1'b0;
    case (state)
      S_FETCH: begin
        mem_re_c = 1'b1;
        if (bus.mem_ready) begin
          ir_we_c  = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: state_nx = bad ? S_TRAP : S_EXEC;
      S_EXEC: begin
        state_nx = S_FETCH;
        case (opc)
          OPC_OP: begin
            bus.aluOp = alu_f; rf_we_c = 1'b1; pc_we_c = 1'b1;
          end
          OPC_OPIMM: begin
            bus.aluOp = alu_f; bus.alu_srcB_sel = 3'd1; rf_we_c = 1'b1; pc_we_c = 1'b1;
          end
          OPC_LUI: begin
            bus.alu_srcA_sel = 2'd2; bus.alu_srcB_sel = 3'd3; rf_we_c = 1'b1; pc_we_c = 1'b1;
          end
          OPC_AUIPC: begin
            bus.alu_srcA_sel = 2'd1; bus.alu_srcB_sel = 3'd3; rf_we_c = 1'b1; pc_we_c = 1'b1;
          end
          OPC_JAL, OPC_JALR: begin
            bus.alu_srcA_sel = 2'd1; bus.alu_srcB_sel = 3'd4; rf_we_c = 1'b1; pc_we_c = 1'b1;
            bus.pc_sel = (opc == OPC_JAL) ? 2'd2 : 2'd3;
          end
          OPC_BRANCH: begin
            pc_we_c = 1'b1; bus.pc_sel = {1'b0, bus.br_taken};
          end
          OPC_LOAD: begin
            bus.alu_srcB_sel = 3'd1; state_nx = S_MEM;
          end
          OPC_STORE: begin
            bus.alu_srcB_sel = 3'd2; state_nx = S_MEM;
          end
          default: state_nx = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (opc == OPC_LOAD) begin
          mem_re_c = 1'b1;
          if (bus.mem_ready) state_nx = S_WB;
        end else begin
          mem_we_c = 1'b1;
          if (bus.mem_ready) begin
            pc_we_c  = 1'b1;
            state_nx = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we_c = 1'b1; bus.rf_wsel = 1'b1; pc_we_c = 1'b1; state_nx = S_FETCH;
      end
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_FETCH;
    endcase
  end

  // Strobes are gated by rst directly so they drop without waiting for a clock.
  assign bus.pc_we  = pc_we_c  & ~rst;
  assign bus.ir_we  = ir_we_c  & ~rst;
  assign bus.rf_we  = rf_we_c  & ~rst;
  assign bus.mem_re = mem_re_c & ~rst;
  assign bus.mem_we = mem_we_c & ~rst;

  assign illegal = (state == S_TRAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= state_nx;
      if (bus.pc_we) instret <= instret + 1'b1;
    end
  end
endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Bench for rv_ctrl_fsm: directed test-plan scenarios plus random instruction
// words checked against a per-instruction expectation model.
module tb_rv_ctrl_fsm;
  localparam int CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;
  localparam logic [6:0] OPS [11] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67,
                                      7'h63, 7'h03, 7'h23, 7'h0F, 7'h73};
  localparam logic [3:0] F3ALU [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  typedef struct {
    bit         ill;
    bit         ld;
    bit         st;
    logic [3:0] alu;
    logic [1:0] sa;
    logic [2:0] sb;
    logic [1:0] ps;
    logic [4:0] stb;   // {pc_we, ir_we, rf_we, mem_re, mem_we} during EXEC
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic illegal;
  logic [CNT_W-1:0] instret;
  logic [4:0] stb;
  int errors = 0, checks = 0, cnt = 0;

  rv_ctrl_if bus ();
  rv_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.master), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;
  assign stb = {bus.pc_we, bus.ir_we, bus.rf_we, bus.mem_re, bus.mem_we};

  // Expected EXEC-state behaviour of one instruction, from the ISA rules.
  function automatic exp_t model(input logic [31:0] i, input bit bt);
    exp_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [7:0] f3ok;
    bit f7ok;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    e = '{ill: 1'b0, ld: 1'b0, st: 1'b0, alu: 4'd0, sa: 2'd0, sb: 3'd0, ps: 2'd0, stb: 5'b0};
    f3ok = 8'hFF; f7ok = 1'b1;
    case (op)
      7'h33: begin
        e.stb = 5'b10100;
        f7ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'h13: begin
        e.sb = 3'd1; e.stb = 5'b10100;
        if (f3 == 3'd1) f7ok = (f7 == 7'h00);
        if (f3 == 3'd5) f7ok = (f7 == 7'h00 || f7 == 7'h20);
      end
      7'h37: begin e.sa = 2'd2; e.sb = 3'd3; e.stb = 5'b10100; end
      7'h17: begin e.sa = 2'd1; e.sb = 3'd3; e.stb = 5'b10100; end
      7'h6F: begin e.sa = 2'd1; e.sb = 3'd4; e.ps = 2'd2; e.stb = 5'b10100; end
      7'h67: begin e.sa = 2'd1; e.sb = 3'd4; e.ps = 2'd3; e.stb = 5'b10100; f3ok = 8'h01; end
      7'h63: begin e.ps = bt ? 2'd1 : 2'd0; e.stb = 5'b10000; f3ok = 8'b1111_0011; end
      7'h03: begin e.sb = 3'd1; e.ld = 1'b1; f3ok = 8'b0011_0111; end
      7'h23: begin e.sb = 3'd2; e.st = 1'b1; f3ok = 8'b0000_0111; end
      default: e.ill = 1'b1;
    endcase
    if (op == 7'h33 || op == 7'h13) begin
      e.alu = F3ALU[f3];
      if (f3 == 3'd0 && op == 7'h33 && i[30]) e.alu = 4'd1;
      if (f3 == 3'd5 && i[30]) e.alu = 4'd7;
    end
    if (!f3ok[f3] || !f7ok) e.ill = 1'b1;
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1; bus.mem_ready = 1'b1; bus.br_taken = 1'b1;
    @(negedge clk); checks++;
    if ({stb, bus.aluOp, bus.alu_srcA_sel, bus.alu_srcB_sel, bus.pc_sel, bus.rf_wsel,
         illegal, instret} !== '0)
      begin errors++; $display("FAIL reset_state stb=%b alu=%0d sa=%0d sb=%0d ps=%0d ill=%b cnt=%0d exp all 0",
        stb, bus.aluOp, bus.alu_srcA_sel, bus.alu_srcB_sel, bus.pc_sel, illegal, instret); end
    @(posedge clk); #1 rst = 1'b0; cnt = 0;
  endtask

  // Runs one instruction from FETCH. abort_k >= 0 fires an async reset in that MEM cycle.
  task automatic exec_instr(input logic [31:0] ins, input int wait_n, input bit bt,
                            input int abort_k, input int trap_n);
    exp_t e;
    e = model(ins, bt);
    bus.mem_ready = 1'b1; bus.br_taken = bt; bus.ir = $urandom;
    @(negedge clk); checks++;
    if (stb !== 5'b01010) begin errors++; $display("FAIL fetch ins=%h stb=%b exp=01010", ins, stb); end
    @(posedge clk); #1 bus.ir = ins;
    @(negedge clk); checks++;
    if ({stb, illegal} !== 6'b0) begin errors++; $display("FAIL decode ins=%h stb=%b ill=%b exp 0", ins, stb, illegal); end
    @(posedge clk); #1;
    if (e.ill) begin
      repeat (trap_n) begin
        @(negedge clk); checks++;
        if ({illegal, stb, bus.aluOp, instret} !== {1'b1, 5'b0, 4'd0, cnt[CNT_W-1:0]})
          begin errors++; $display("FAIL trap ins=%h ill=%b stb=%b alu=%0d cnt=%0d exp ill=1 cnt=%0d",
            ins, illegal, stb, bus.aluOp, instret, cnt); end
        @(posedge clk); #1;
      end
      return;
    end
    @(negedge clk); checks++;
    if ({bus.aluOp, bus.alu_srcA_sel, bus.alu_srcB_sel, bus.pc_sel, bus.rf_wsel, stb} !==
        {e.alu, e.sa, e.sb, e.ps, 1'b0, e.stb})
      begin errors++; $display("FAIL exec ins=%h alu=%0d sa=%0d sb=%0d ps=%0d stb=%b exp alu=%0d sa=%0d sb=%0d ps=%0d stb=%b",
        ins, bus.aluOp, bus.alu_srcA_sel, bus.alu_srcB_sel, bus.pc_sel, stb, e.alu, e.sa, e.sb, e.ps, e.stb); end
    @(posedge clk); #1;
    if (e.ld || e.st) begin
      for (int k = 0; k <= wait_n; k++) begin
        bus.mem_ready = (k == wait_n);
        if (k == abort_k) begin
          #2; checks++;
          if ({stb, instret} !== {5'b00001, cnt[CNT_W-1:0]})
            begin errors++; $display("FAIL pre_abort stb=%b cnt=%0d exp stb=00001 cnt=%0d", stb, instret, cnt); end
          rst = 1'b1; #1; checks++; cnt = 0;
          if ({stb, instret, illegal} !== '0)
            begin errors++; $display("FAIL async_abort stb=%b cnt=%0d ill=%b exp all 0", stb, instret, illegal); end
          @(posedge clk); #1 rst = 1'b0;
          @(negedge clk); checks++;
          if (stb !== 5'b00010) begin errors++; $display("FAIL post_abort_fetch stb=%b exp=00010", stb); end
          @(posedge clk); #1;
          return;
        end
        @(negedge clk); checks++;
        if ({stb, instret} !== {(e.ld ? 5'b00010 : (k == wait_n ? 5'b10001 : 5'b00001)), cnt[CNT_W-1:0]})
          begin errors++; $display("FAIL mem ins=%h k=%0d stb=%b cnt=%0d exp cnt=%0d", ins, k, stb, instret, cnt); end
        @(posedge clk); #1;
      end
      if (e.ld) begin
        bus.mem_ready = 1'b1;
        @(negedge clk); checks++;
        if ({stb, bus.rf_wsel, bus.pc_sel} !== {5'b10100, 1'b1, 2'd0})
          begin errors++; $display("FAIL wb ins=%h stb=%b wsel=%b ps=%0d exp 10100/1/0", ins, stb, bus.rf_wsel, bus.pc_sel); end
        @(posedge clk); #1;
      end
    end
    cnt = (cnt + 1) % CNT_MOD; checks++;
    if (instret !== cnt[CNT_W-1:0]) begin errors++; $display("FAIL instret ins=%h got=%0d exp=%0d", ins, instret, cnt); end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_alu();
    logic [31:0] prog [8] = '{32'h002081B3, 32'h402081B3, 32'h4020D1B3, 32'h4040D193,
                              32'h123450B7, 32'h00001097, 32'h008000EF, 32'h000080E7};
    foreach (prog[i]) exec_instr(prog[i], 0, 1'b0, -1, 0);
  endtask

  task automatic test_mem();
    int t0;
    t0 = $time;
    exec_instr(32'h0080A283, 3, 1'b0, -1, 0);
    checks++;
    if (($time - t0) / 10 != 8) begin errors++; $display("FAIL lw_cycles got=%0d exp=8", ($time - t0) / 10); end
    exec_instr(32'h0020A423, 0, 1'b0, -1, 0);
  endtask

  task automatic test_branch();
    exec_instr(32'h00208463, 0, 1'b1, -1, 0);
    exec_instr(32'h00208463, 0, 1'b0, -1, 0);
  endtask

  task automatic test_trap();
    exec_instr(32'hFFFFFFFF, 0, 1'b0, -1, 12);
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    exec_instr(32'h00100093, 0, 1'b0, -1, 0);
    exec_instr(32'h0020A423, 5, 1'b0, 2, 0);
    exec_instr(32'h002081B3, 0, 1'b0, -1, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < CNT_MOD + 3; i++) exec_instr(32'h00108093, 0, 1'b0, -1, 0);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    exp_t e;
    bit bt;
    for (int n = 0; n < 120; n++) begin
      ins = $urandom;
      ins[6:0] = OPS[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        default: ;
      endcase
      if ($urandom_range(0, 15) == 0) ins[1:0] = 2'($urandom_range(0, 2));
      bt = 1'($urandom_range(0, 1));
      e = model(ins, bt);
      exec_instr(ins, $urandom_range(0, 3), bt, -1, 2);
      if (e.ill) do_reset();
    end
  endtask

  initial begin
    bus.ir = '0; bus.mem_ready = 1'b0; bus.br_taken = 1'b0;
    #1;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_trap();
    test_reset_mid_mem();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
